// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: register file geometry, reset constants and
// the dump reader state encoding.
package cpu_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned REG_NUM  = 32;
  localparam logic [31:0] SP_RESET = 32'h0000_0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready beat stream carrying {index, data} from the register dump reader.
interface regfile_dump_reader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);

  logic             OUT_VALID;
  logic             OUT_READY;
  logic [AW-1:0]    OUT_IDX;
  logic [WIDTH-1:0] OUT_DATA;

  modport master (
    output OUT_VALID,
    output OUT_IDX,
    output OUT_DATA,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID,
    input  OUT_IDX,
    input  OUT_DATA,
    output OUT_READY
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register range through the register file's debug read port and
// streams each register as an {index, data} beat, with a running XOR checksum.
module regfile_dump_reader
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = REG_AW
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [AW-1:0]          FIRST,
  input  logic [AW-1:0]          LAST,
  input  logic                   ABORT,
  output logic [AW-1:0]          RA3,
  input  logic [WIDTH-1:0]       RD3,
  regfile_dump_reader_if.master  out,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ABORTED,
  output logic [WIDTH-1:0]       CSUM
);

  dump_state_t   state_q;
  dump_state_t   state_d;
  logic [AW-1:0] cur_q;
  logic [AW-1:0] last_q;
  logic          hs_c;
  logic          abort_c;

  // Next-state decode; ABORT only matters while a dump is actually reading or sending.
  always_comb begin
    state_d = state_q;
    abort_c = 1'b0;
    hs_c    = (state_q == SEND) && out.OUT_VALID && out.OUT_READY;
    case (state_q)
      IDLE: if (START) state_d = READ;
      READ: begin
        if (ABORT) begin
          state_d = FIN;
          abort_c = 1'b1;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (ABORT) begin
          state_d = FIN;
          abort_c = 1'b1;
        end else if (hs_c) begin
          state_d = (cur_q == last_q) ? FIN : READ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: range pointers, read address, output beat and checksum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_q         <= '0;
      last_q        <= '0;
      RA3           <= '0;
      out.OUT_VALID <= 1'b0;
      out.OUT_IDX   <= '0;
      out.OUT_DATA  <= '0;
      CSUM          <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      ABORTED       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            cur_q  <= FIRST;
            last_q <= LAST;
            RA3    <= FIRST;
            CSUM   <= '0;
          end
        end
        READ: begin
          if (!ABORT) begin
            out.OUT_VALID <= 1'b1;
            out.OUT_IDX   <= cur_q;
            out.OUT_DATA  <= RD3;
          end
        end
        SEND: begin
          // A beat handshaken alongside ABORT still counts toward the checksum.
          if (hs_c) begin
            CSUM          <= CSUM ^ out.OUT_DATA;
            out.OUT_VALID <= 1'b0;
            if (!ABORT && (cur_q != last_q)) begin
              cur_q <= cur_q + AW'(1);
              RA3   <= cur_q + AW'(1);
            end
          end
          if (ABORT) out.OUT_VALID <= 1'b0;
        end
        default: ;
      endcase
      BUSY    <= (state_d != IDLE);
      DONE    <= (state_d == FIN);
      ABORTED <= (state_d == FIN) && abort_c;
    end
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug-side reader for the processor register file. It drives the register file's third read port (address out, data in) to walk a programmable register range. Each captured register is streamed out as an {index, data} beat on a valid/ready interface, for the debug UART/trace path. A running XOR checksum of the dump is reported at completion.

Parameters:
WIDTH, 32, register data width
AW, 5, register address width (32 registers)

Ports:
CLK  input  1  system clock, posedge active
RST  input  1  reset, asynchronous, active-high
START  input  1  one-cycle request to begin a dump; honoured only in IDLE
FIRST  input  AW  first register index, sampled on accepted START
LAST  input  AW  last register index, sampled on accepted START
ABORT  input  1  terminate the current dump
RA3  output  AW  register file read address (debug port)
RD3  input  WIDTH  register file read data (combinational from RA3)
OUT_VALID  output  1  output beat valid
OUT_READY  input  1  downstream accepts beat
OUT_IDX  output  AW  register index of the beat
OUT_DATA  output  WIDTH  register value of the beat
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle pulse when a dump completes or is aborted
ABORTED  output  1  qualifies DONE; high with DONE only for an aborted dump
CSUM  output  WIDTH  XOR of all OUT_DATA beats accepted in the last dump; stable after DONE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; RA3=0, OUT_VALID=0, OUT_IDX=0, OUT_DATA=0, BUSY=0, DONE=0, ABORTED=0, CSUM=0; cur/last registers=0. A dump in flight is discarded; no DONE is issued.
- States: IDLE, READ, SEND, FIN.
- IDLE: on START, latch cur=FIRST, last=LAST, clear CSUM, drive RA3=FIRST, go READ. START in any other state is ignored.
- READ (1 cycle): RA3=cur. At the posedge, capture OUT_DATA=RD3 and OUT_IDX=cur, set OUT_VALID=1, go SEND.
- SEND: OUT_VALID, OUT_IDX and OUT_DATA are held stable until OUT_READY=1. On a handshake (valid&ready):
  - CSUM ^= OUT_DATA and OUT_VALID=0.
  - If cur==last, go FIN.
  - Otherwise cur=cur+1 modulo 2^AW, RA3=cur+1, go READ.
- FIN: DONE=1 for one cycle, ABORTED as set, then go IDLE.
- Latency: START at edge N. READ in cycle N+1. OUT_VALID high from edge N+2. With OUT_READY tied high, throughput is 1 beat per 2 cycles.
- Range and wrap: beat count = ((LAST-FIRST) mod 32)+1.
  - FIRST==LAST gives exactly 1 beat.
  - LAST<FIRST wraps through 31 to 0; e.g. FIRST=30, LAST=1 gives indices 30,31,0,1.
  - No zero-length dump exists.
- Register 0 is read through the port and reads 0.
- ABORT in READ or SEND:
  - Go FIN at the next edge and drop OUT_VALID.
  - A beat whose handshake occurs in the same cycle as ABORT is counted, and is included in CSUM.
  - ABORTED=1 with DONE.
  - ABORT in IDLE or FIN has no effect.
- Simultaneous START and ABORT in IDLE: START wins and ABORT is ignored.
- Coherency: each register is sampled at the posedge ending its READ cycle. The register file writes on negedge, so a write in the half cycle before sampling is visible. No atomic snapshot across registers is guaranteed.
- OUT_READY high in READ, FIN or IDLE has no effect.

Decomposition:
- Shared package (cpu_pkg): REG_AW=5, REG_NUM=32, SP_RESET=32'h100, and a state enum type dump_state_t {IDLE, READ, SEND, FIN}.
- No sub-module. The output beat register is inline; a skid buffer is unnecessary at 1 beat per 2 cycles.

Test Plan:
- After reset, START with FIRST=0, LAST=31, OUT_READY=1 -> 32 beats with OUT_IDX 0..31. Beat 29 carries 0x00000100 and all others 0. DONE pulses with CSUM=0x00000100 and ABORTED=0.
- Preload r8=0xDEADBEEF; START FIRST=8, LAST=8 -> exactly one beat (8, 0xDEADBEEF). OUT_VALID first seen 2 edges after START. CSUM=0xDEADBEEF.
- FIRST=30, LAST=1 with r30=1, r31=2, r1=4 -> OUT_IDX order 30,31,0,1 and CSUM=0x7.
- Random OUT_READY stalls of 0-5 cycles -> OUT_IDX and OUT_DATA are unchanged while OUT_VALID=1 and OUT_READY=0. There are no dropped or duplicated beats, and a second START during BUSY is ignored.
- ABORT asserted on the 3rd beat's handshake cycle with FIRST=0, LAST=31 -> 3 beats accepted, then DONE=1 with ABORTED=1. CSUM equals the XOR of r0..r2.
- Assert RST mid-SEND -> all outputs are 0 immediately (asynchronously), no DONE is issued, and a new START then behaves normally.
